// File: rtl/gate_net_sequencer_if.sv
// rtl/gate_net_sequencer_if.sv - signal bundle between the self-test sequencer and the gate network
//
// Purpose: carries the three network inputs driven by the sequencer and the two
//          network outputs it samples.
// Ports (modports):
//   master  - sequencer side: drives dut_a/dut_b/dut_c, reads dut_x/dut_y
//   slave   - network side:   reads dut_a/dut_b/dut_c, drives dut_x/dut_y
interface gate_net_sequencer_if;
    logic dut_a;
    logic dut_b;
    logic dut_c;
    logic dut_x;
    logic dut_y;

    modport master (
        output dut_a, dut_b, dut_c,
        input  dut_x, dut_y
    );

    modport slave (
        input  dut_a, dut_b, dut_c,
        output dut_x, dut_y
    );
endinterface

// File: rtl/gate_net_sequencer.sv
// rtl/gate_net_sequencer.sv - self-test sequencer for the OR/NAND/XOR gate network
//
// Purpose: on start, sweeps all 8 {a,b,c} vectors into the gate network NUM_PASSES
//          times, holds each for SETTLE_CYCLES, samples {x,y} for one cycle and checks
//          it against a built-in golden table. Reports pass, a saturating mismatch
//          count and the first failing vector.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start, abort    run control (start sampled only in IDLE; abort wins)
//   net             gate network bundle (master side)
//   busy            high while driving/sampling
//   done            one-cycle pulse on normal completion
//   pass            last completed run had zero mismatches
//   err_count       mismatches in the current/last run, saturating
//   fail_valid      a mismatch has been recorded this run
//   fail_vec        {a,b,c} of the first mismatch this run
module gate_net_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    gate_net_sequencer_if.master net,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic                 fail_valid,
    output logic [2:0]           fail_vec
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    // Golden responses, bit i is the expected output for vec {a,b,c} = i.
    localparam logic [7:0] GOLD_X = 8'hA9;
    localparam logic [7:0] GOLD_Y = 8'h3C;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       settle_cnt;
    logic [7:0]       pass_cnt;
    logic [2:0]       vec;
    logic [2:0]       drive_q;
    logic             accept;
    logic             sample_now;
    logic             finish;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;
    logic [ERR_W-1:0] err_final;

    assign net.dut_a = drive_q[2];
    assign net.dut_b = drive_q[1];
    assign net.dut_c = drive_q[0];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        sample_now = 1'b0;
        finish     = 1'b0;
        mismatch   = (net.dut_x != GOLD_X[vec]) || (net.dut_y != GOLD_Y[vec]);
        err_inc    = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_ONE;
        // pass on the final sample must include a mismatch found in that same cycle
        err_final  = mismatch ? err_inc : err_count;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = DRIVE;
                    accept  = 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // an abort landing on the sample cycle discards that sample
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    sample_now = 1'b1;
                    if (vec == 3'd7 && pass_cnt == PASS_LAST) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DRIVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_cnt <= 4'd0;
            pass_cnt   <= 8'd0;
            vec        <= 3'd0;
            drive_q    <= 3'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 3'd0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            // counts cycles already spent in DRIVE; cleared on every entry
            settle_cnt <= (state_q == DRIVE && state_d == DRIVE) ? settle_cnt + 4'd1 : 4'd0;

            if (accept) begin
                vec        <= 3'd0;
                pass_cnt   <= 8'd0;
                err_count  <= '0;
                fail_valid <= 1'b0;
                fail_vec   <= 3'd0;
                pass       <= 1'b0;
                drive_q    <= 3'd0;
            end

            if (busy && abort) begin
                drive_q <= 3'd0;
                pass    <= 1'b0;
            end

            if (sample_now) begin
                if (mismatch) begin
                    err_count <= err_inc;
                    if (!fail_valid) begin
                        fail_vec   <= vec;
                        fail_valid <= 1'b1;
                    end
                end
                if (finish) begin
                    done    <= 1'b1;
                    pass    <= (err_final == '0);
                    drive_q <= 3'd0;
                    vec     <= 3'd0;
                end else begin
                    vec     <= vec + 3'd1;
                    drive_q <= vec + 3'd1;
                    if (vec == 3'd7) begin
                        pass_cnt <= pass_cnt + 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_net_sequencer.sv
// tb/tb_gate_net_sequencer.sv - self-checking bench for gate_net_sequencer
module tb_gate_net_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start1 = 1'b0, abort0 = 1'b0, abort1 = 1'b0;
    logic busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
    logic [3:0] err0;
    logic [2:0] err1, fvec0, fvec1;
    logic [1:0] tbl0 [8];
    logic [1:0] tbl1 [8];
    int sel = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_net_sequencer_if n0 ();
    gate_net_sequencer_if n1 ();

    // behavioural gate networks: truth table looked up by the applied vector
    assign n0.dut_x = tbl0[{n0.dut_a, n0.dut_b, n0.dut_c}][1];
    assign n0.dut_y = tbl0[{n0.dut_a, n0.dut_b, n0.dut_c}][0];
    assign n1.dut_x = tbl1[{n1.dut_a, n1.dut_b, n1.dut_c}][1];
    assign n1.dut_y = tbl1[{n1.dut_a, n1.dut_b, n1.dut_c}][0];

    gate_net_sequencer #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .net(n0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_valid(fv0), .fail_vec(fvec0)
    );

    gate_net_sequencer #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_W(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .net(n1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_valid(fv1), .fail_vec(fvec1)
    );

    wire       busy_s = (sel != 0) ? busy1 : busy0;
    wire       done_s = (sel != 0) ? done1 : done0;
    wire       pass_s = (sel != 0) ? pass1 : pass0;
    wire       fv_s   = (sel != 0) ? fv1 : fv0;
    wire [3:0] err_s  = (sel != 0) ? {1'b0, err1} : err0;
    wire [2:0] fvec_s = (sel != 0) ? fvec1 : fvec0;
    wire [2:0] pins_s = (sel != 0) ? {n1.dut_a, n1.dut_b, n1.dut_c}
                                   : {n0.dut_a, n0.dut_b, n0.dut_c};

    function automatic int cfg_s();  return (sel != 0) ? 1 : 2; endfunction
    function automatic int cfg_p();  return (sel != 0) ? 2 : 1; endfunction
    function automatic int cfg_w();  return (sel != 0) ? 3 : 4; endfunction

    // reference network behaviour: x = ~c ^ (a|b), y = a ^ b
    function automatic logic [1:0] gold(input int v);
        logic a, b, c;
        a = v[2]; b = v[1]; c = v[0];
        return {~c ^ (a | b), a ^ b};
    endfunction

    function automatic logic [1:0] net_tbl(input int v);
        return (sel != 0) ? tbl1[v] : tbl0[v];
    endfunction

    // mismatches seen in the first 'samples' samples of the sweep sequence
    function automatic int miss(input int samples);
        int m = 0;
        for (int i = 0; i < samples; i++) if (net_tbl(i % 8) !== gold(i % 8)) m++;
        return m;
    endfunction

    function automatic int first_miss(input int samples);
        for (int i = 0; i < samples; i++) if (net_tbl(i % 8) !== gold(i % 8)) return i % 8;
        return 0;
    endfunction

    function automatic int sat(input int raw);
        int mx = (1 << cfg_w()) - 1;
        return (raw > mx) ? mx : raw;
    endfunction

    task automatic set_tbl(input int mode);
        logic [1:0] t;
        for (int v = 0; v < 8; v++) begin
            t = gold(v);
            case (mode)
                1: t[0] = 1'b0;
                2: t[1] = ~t[1];
                3: if ($urandom % 3 == 0) t = t ^ 2'($urandom_range(1, 3));
                default: ;
            endcase
            if (sel != 0) tbl1[v] = t; else tbl0[v] = t;
        end
    endtask

    task automatic set_start(input logic v);
        if (sel != 0) start1 = v; else start0 = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel != 0) abort1 = v; else abort0 = v;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // starts a run and observes it; got = cycles from start accept to done (-1 if none)
    task automatic run_driver(input int abort_at, input bit poke, output int got, output int pin_bad);
        int s, len;
        s = cfg_s();
        len = 8 * cfg_p() * (s + 1);
        got = -1;
        pin_bad = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int n = 0; n <= len + 5; n++) begin
            if (abort_at < 0 && n < len)
                if (pins_s !== 3'((n / (s + 1)) % 8) || busy_s !== 1'b1) pin_bad++;
            if (n == abort_at) set_abort(1'b1);
            if (poke && n < len - 1 && ($urandom % 4) == 0) set_start(1'b1);
            tick();
            set_abort(1'b0);
            set_start(1'b0);
            if (done_s === 1'b1) begin got = n + 1; break; end
            if (abort_at >= 0 && n == abort_at) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            checks++;
            if ({busy_s, done_s, pass_s, fv_s, err_s, fvec_s, pins_s} !== 15'd0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got=%b expected=0", i,
                         {busy_s, done_s, pass_s, fv_s, err_s, fvec_s, pins_s});
            end
        end
    endtask

    task automatic test_golden();
        int got, pb;
        sel = 0; set_tbl(0);
        run_driver(-1, 0, got, pb);
        checks++; if (got !== 24) begin errors++; $display("FAIL golden_len got=%0d expected=24", got); end
        checks++; if (pb !== 0) begin errors++; $display("FAIL golden_pins bad=%0d expected=0", pb); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL golden_busy_done got=%b expected=0", busy_s); end
        checks++; if ({pass_s, fv_s, err_s} !== 6'b100000) begin
            errors++; $display("FAIL golden_result got=%b expected=100000", {pass_s, fv_s, err_s}); end
        tick();
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL golden_done_width got=%b expected=0", done_s); end
    endtask

    task automatic test_stuck_y();
        int got, pb;
        sel = 0; set_tbl(1);
        run_driver(-1, 0, got, pb);
        checks++; if (got !== 24) begin errors++; $display("FAIL stuck_len got=%0d expected=24", got); end
        checks++; if (err_s !== 4'd4) begin errors++; $display("FAIL stuck_err got=%0d expected=4", err_s); end
        checks++; if ({pass_s, fv_s, fvec_s} !== 5'b01010) begin
            errors++; $display("FAIL stuck_fail got=%b expected=01010", {pass_s, fv_s, fvec_s}); end
    endtask

    task automatic test_start_abort_idle();
        sel = 0;
        start0 = 1'b1; abort0 = 1'b1;
        tick();
        start0 = 1'b0; abort0 = 1'b0;
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL start_abort_idle_busy got=%b expected=0", busy_s); end
        tick();
        checks++; if ({busy_s, err_s, fv_s, fvec_s} !== 9'b0_0100_1010) begin
            errors++; $display("FAIL start_abort_idle_hold got=%b expected=001001010", {busy_s, err_s, fv_s, fvec_s}); end
    endtask

    task automatic test_saturate();
        int got, pb;
        sel = 1; set_tbl(2);
        run_driver(-1, 0, got, pb);
        checks++; if (got !== 32) begin errors++; $display("FAIL sat_len got=%0d expected=32", got); end
        checks++; if (err_s !== 4'd7) begin errors++; $display("FAIL sat_err got=%0d expected=7", err_s); end
        checks++; if ({pass_s, fv_s, fvec_s} !== 5'b01000) begin
            errors++; $display("FAIL sat_fail got=%b expected=01000", {pass_s, fv_s, fvec_s}); end
    endtask

    task automatic test_settle1_order();
        int got, pb;
        sel = 1; set_tbl(0);
        run_driver(-1, 0, got, pb);
        checks++; if (pb !== 0) begin errors++; $display("FAIL settle1_pins bad=%0d expected=0", pb); end
        checks++; if (got !== 32) begin errors++; $display("FAIL settle1_len got=%0d expected=32", got); end
        checks++; if (pass_s !== 1'b1) begin errors++; $display("FAIL settle1_pass got=%b expected=1", pass_s); end
    endtask

    task automatic test_random();
        int got, pb, raw, len;
        for (int it = 0; it < 8; it++) begin
            sel = $urandom % 2;
            set_tbl(3);
            len = 8 * cfg_p() * (cfg_s() + 1);
            raw = miss(8 * cfg_p());
            run_driver(-1, 0, got, pb);
            checks++; if (got !== len) begin errors++; $display("FAIL rand_len it=%0d got=%0d expected=%0d", it, got, len); end
            checks++; if (pb !== 0) begin errors++; $display("FAIL rand_pins it=%0d bad=%0d expected=0", it, pb); end
            checks++; if (int'(err_s) !== sat(raw)) begin
                errors++; $display("FAIL rand_err it=%0d got=%0d expected=%0d", it, err_s, sat(raw)); end
            checks++; if (pass_s !== (raw == 0) || fv_s !== (raw != 0)) begin
                errors++; $display("FAIL rand_pass it=%0d got=%b%b expected=%b%b", it, pass_s, fv_s, raw == 0, raw != 0); end
            if (raw != 0) begin
                checks++; if (int'(fvec_s) !== first_miss(8)) begin
                    errors++; $display("FAIL rand_fvec it=%0d got=%0d expected=%0d", it, fvec_s, first_miss(8)); end
            end
        end
    endtask

    task automatic test_abort();
        int got, pb, k, done_seen, part;
        sel = 0;
        for (int it = 0; it < 4; it++) begin
            set_tbl(it == 0 ? 1 : 3);
            if (it == 0) k = 10;
            else begin
                k = $urandom_range(0, 22);
                if (k % 3 == 2) k = k - 1;
            end
            part = miss(k / 3);
            run_driver(k, 0, got, pb);
            checks++; if ({busy_s, done_s, pass_s, pins_s} !== 6'd0) begin
                errors++; $display("FAIL abort_state k=%0d got=%b expected=000000", k, {busy_s, done_s, pass_s, pins_s}); end
            checks++; if (int'(err_s) !== sat(part) || fv_s !== (part != 0)) begin
                errors++; $display("FAIL abort_partial k=%0d got=%0d/%b expected=%0d/%b", k, err_s, fv_s, sat(part), part != 0); end
            done_seen = 0;
            for (int n = 0; n < 30; n++) begin tick(); if (done_s === 1'b1) done_seen++; end
            checks++; if (done_seen !== 0 || busy_s !== 1'b0) begin
                errors++; $display("FAIL abort_no_done k=%0d done_cycles=%0d busy=%b expected=0,0", k, done_seen, busy_s); end
        end
        set_tbl(0);
        run_driver(-1, 0, got, pb);
        checks++; if (got !== 24 || pass_s !== 1'b1 || err_s !== 4'd0) begin
            errors++; $display("FAIL abort_rerun got len=%0d pass=%b err=%0d expected 24,1,0", got, pass_s, err_s); end
    endtask

    task automatic test_back_to_back();
        int got, pb;
        sel = 0; set_tbl(0);
        run_driver(-1, 1, got, pb);
        checks++; if (got !== 24 || pb !== 0) begin
            errors++; $display("FAIL busy_start_ignored len=%0d pins_bad=%0d expected 24,0", got, pb); end
        sel = 1; set_tbl(0);
        run_driver(-1, 1, got, pb);
        checks++; if (got !== 32 || pass_s !== 1'b1) begin
            errors++; $display("FAIL busy_start_ignored1 len=%0d pass=%b expected 32,1", got, pass_s); end
    endtask

    task automatic test_reset_mid();
        sel = 0; set_tbl(1);
        set_start(1'b1); tick(); set_start(1'b0);
        repeat (10) tick();
        checks++; if (busy_s !== 1'b1 || err_s !== 4'd1) begin
            errors++; $display("FAIL midrun_progress busy=%b err=%0d expected 1,1", busy_s, err_s); end
        rst = 1'b1; start0 = 1'b1; abort0 = 1'b1;
        tick();
        rst = 1'b0; start0 = 1'b0; abort0 = 1'b0;
        checks++; if ({busy_s, done_s, pass_s, fv_s, err_s, fvec_s, pins_s} !== 15'd0) begin
            errors++; $display("FAIL midrun_reset got=%b expected=0", {busy_s, done_s, pass_s, fv_s, err_s, fvec_s, pins_s}); end
    endtask

    initial begin
        for (int v = 0; v < 8; v++) begin tbl0[v] = gold(v); tbl1[v] = gold(v); end
        test_reset();
        test_golden();
        test_stuck_y();
        test_start_abort_idle();
        test_saturate();
        test_settle1_order();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
